result_fifo_bank: RTL and testbench

RESULT_FIFO_BANK -- requirements
Module: result_fifo_bank

---
 rtl/result_fifo_bank_if.sv | 27 ++
 rtl/result_fifo_bank.sv | 140 ++++++++++++++
 tb/tb_result_fifo_bank.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_fifo_bank_if.sv
// Bundle of the PE-cube result signals: per-lane push/pop strobes and data,
// group select, error clear, and the packed write word, fill flag and errors
// returned to the controller.
interface result_fifo_bank_if #(
    parameter int LANES = 27
);
    logic [LANES-1:0]   iResultValid;
    logic [8*LANES-1:0] iResultData;
    logic [LANES-1:0]   iResultRdEn;
    logic [2:0]         iResultFifoSel;
    logic               iClrErr;
    logic               oAllResultFifoHasData;
    logic [31:0]        oWrData;
    logic [1:0]         oErr;

    // Controller / PE side drives strobes and data, observes the bank outputs.
    modport master (
        output iResultValid, iResultData, iResultRdEn, iResultFifoSel, iClrErr,
        input  oAllResultFifoHasData, oWrData, oErr
    );

    // The bank itself.
    modport slave (
        input  iResultValid, iResultData, iResultRdEn, iResultFifoSel, iClrErr,
        output oAllResultFifoHasData, oWrData, oErr
    );
endinterface

// File: rtl/result_fifo_bank.sv
// result_fifo_bank: one 8-bit FIFO per PE lane (LANES = ARRAY*BLOCK*CUBE).
// Pops land in a per-lane read register one cycle later; a 4-lane group of
// those registers, chosen by iResultFifoSel, is packed into oWrData.
// Optional macro SC_RESULT_FIFO_STATUS_EN enables sticky overflow/underflow
// flags on oErr; without it oErr is constant zero and iClrErr is ignored.
module result_fifo_bank #(
    parameter int ARRAY_NUM  = 3,
    parameter int BLOCK_NUM  = 3,
    parameter int CUBE_NUM   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    result_fifo_bank_if.slave bus
);
    localparam int LANES = ARRAY_NUM * BLOCK_NUM * CUBE_NUM;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    // 3-bit select times 4 lanes per group addresses 32 lane slots.
    localparam int SLOTS = 32;

    logic [LANES-1:0]   nonempty_next;
    logic [8*LANES-1:0] rd_q_flat;
    logic [7:0]         lane_pad [SLOTS];
    logic               all_has_data_reg;

`ifdef SC_RESULT_FIFO_STATUS_EN
    logic [LANES-1:0]   ovf_vec;
    logic [LANES-1:0]   udf_vec;
    logic [1:0]         err_reg;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0]    mem_reg [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr_reg;
        logic [AW-1:0] rd_ptr_reg;
        logic [CW-1:0] count_reg;
        logic [CW-1:0] count_next;
        logic [7:0]    rd_q_reg;
        logic          full;
        logic          empty;
        logic          pop_ok;
        logic          push_ok;

        assign full    = (count_reg == CW'(FIFO_DEPTH));
        assign empty   = (count_reg == '0);
        assign pop_ok  = bus.iResultRdEn[gi] && !empty;
        // A pop in the same cycle frees the slot, so a full lane still accepts.
        assign push_ok = bus.iResultValid[gi] && (!full || pop_ok);

        // Occupancy after this cycle's accepted push and pop.
        always_comb begin
            count_next = count_reg;
            if (push_ok && !pop_ok) begin
                count_next = count_reg + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count_next = count_reg - CW'(1);
            end
        end

        assign nonempty_next[gi]       = (count_next != '0);
        assign rd_q_flat[8*gi +: 8]    = rd_q_reg;

        // Lane storage; contents need no reset because the pointers define validity.
        always_ff @(posedge iClk) begin
            if (!iRst && push_ok) begin
                mem_reg[wr_ptr_reg] <= bus.iResultData[8*gi +: 8];
            end
        end

        // Pointers, count and the registered read port; empty pops return zero.
        always_ff @(posedge iClk) begin
            if (iRst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
                rd_q_reg   <= 8'h00;
            end else begin
                count_reg <= count_next;
                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    rd_q_reg   <= mem_reg[rd_ptr_reg];
                end else if (bus.iResultRdEn[gi]) begin
                    rd_q_reg   <= 8'h00;
                end
            end
        end

`ifdef SC_RESULT_FIFO_STATUS_EN
        assign ovf_vec[gi] = bus.iResultValid[gi] && full && !bus.iResultRdEn[gi];
        assign udf_vec[gi] = bus.iResultRdEn[gi] && empty;
`endif
    end

    // Pad the read registers out to 32 slots so out-of-range lanes read as zero.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pad
        if (gi < LANES) begin : g_real
            assign lane_pad[gi] = rd_q_flat[8*gi +: 8];
        end else begin : g_zero
            assign lane_pad[gi] = 8'h00;
        end
    end

    // Byte j of the write word is lane 4*sel + j.
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        assign bus.oWrData[8*gi +: 8] = lane_pad[{bus.iResultFifoSel, 2'(gi)}];
    end

    // Fill flag tracks post-update occupancy of every lane.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            all_has_data_reg <= 1'b0;
        end else begin
            all_has_data_reg <= &nonempty_next;
        end
    end

    assign bus.oAllResultFifoHasData = all_has_data_reg;

`ifdef SC_RESULT_FIFO_STATUS_EN
    // Sticky error flags; a new event in the clearing cycle keeps its flag set.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            err_reg <= 2'b00;
        end else begin
            err_reg <= (bus.iClrErr ? 2'b00 : err_reg) | {(|udf_vec), (|ovf_vec)};
        end
    end

    assign bus.oErr = err_reg;
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.iClrErr;
    assign bus.oErr       = 2'b00;
`endif

endmodule

// File: tb/tb_result_fifo_bank.sv
// Bench for result_fifo_bank: queue-based lane model, per-cycle compare on the
// falling edge, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_result_fifo_bank;
    localparam int LANES = 27;
    localparam int DEPTH = 4;
`ifdef SC_RESULT_FIFO_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_fifo_bank_if #(.LANES(LANES)) bus ();

    result_fifo_bank #(
        .ARRAY_NUM (3),
        .BLOCK_NUM (3),
        .CUBE_NUM  (3),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    // Reference state
    logic [7:0] q_m   [LANES][$];
    logic [7:0] rdq_m [LANES];
    logic       all_m;
    logic [1:0] err_m;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_m(input logic [2:0] sel);
        logic [31:0] w;
        int idx;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            idx = 4 * int'(sel) + j;
            if (idx < LANES) w[8*j +: 8] = rdq_m[idx];
        end
        return w;
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        logic ovf;
        logic udf;
        ovf = 1'b0;
        udf = 1'b0;
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                q_m[k].delete();
                rdq_m[k] = 8'h00;
            end
            all_m = 1'b0;
            err_m = 2'b00;
            return;
        end
        for (int k = 0; k < LANES; k++) begin
            if (bus.iResultRdEn[k]) begin
                if (q_m[k].size() == 0) begin
                    rdq_m[k] = 8'h00;
                    udf = 1'b1;
                end else begin
                    rdq_m[k] = q_m[k].pop_front();
                end
            end
            if (bus.iResultValid[k]) begin
                if (q_m[k].size() < DEPTH) q_m[k].push_back(bus.iResultData[8*k +: 8]);
                else ovf = 1'b1;
            end
        end
        all_m = 1'b1;
        for (int k = 0; k < LANES; k++) if (q_m[k].size() == 0) all_m = 1'b0;
        if (STATUS) begin
            if (bus.iClrErr) err_m = 2'b00;
            err_m = err_m | {udf, ovf};
        end else begin
            err_m = 2'b00;
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("has_data", {31'b0, bus.oAllResultFifoHasData}, {31'b0, all_m});
            chk("wr_data", bus.oWrData, word_m(bus.iResultFifoSel));
            chk("err", {30'b0, bus.oErr}, {30'b0, err_m});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus.iResultValid = '0;
        bus.iResultRdEn  = '0;
        bus.iClrErr      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_lane(input int k, input logic [7:0] v);
        bus.iResultValid[k]      = 1'b1;
        bus.iResultData[8*k +: 8] = v;
    endtask

    task automatic push_all(input logic [7:0] base);
        for (int k = 0; k < LANES; k++) push_lane(k, base + 8'(k));
    endtask

    task automatic pop_group(input int s);
        for (int j = 0; j < 4; j++) if (4*s + j < LANES) bus.iResultRdEn[4*s + j] = 1'b1;
    endtask

    task automatic show_sel(input int s);
        bus.iResultFifoSel = 3'(s);
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        bus.iResultValid   = '0;
        bus.iResultData    = '0;
        bus.iResultRdEn    = '0;
        bus.iResultFifoSel = 3'd0;
        bus.iClrErr        = 1'b0;

        // Reset state
        tick();
        tick();
        check_en = 1'b1;
        chk("rst_has", {31'b0, bus.oAllResultFifoHasData}, 32'd0);
        chk("rst_word", bus.oWrData, 32'h0);
        chk("rst_err", {30'b0, bus.oErr}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_word", bus.oWrData, 32'h0);

        // Single push to all lanes, then pop lanes 0-3
        push_all(8'hA0);
        tick();
        chk("s1_has", {31'b0, bus.oAllResultFifoHasData}, 32'd1);
        pop_group(0);
        tick();
        show_sel(0);
        chk("s1_word", bus.oWrData, 32'hA3A2A1A0);
        $display("[TB] single push/pop word=%h", bus.oWrData);

        // Full drain using the 7-step sequence
        do_reset();
        push_all(8'hA0);
        tick();
        for (int s = 0; s < 7; s++) begin
            pop_group(s);
            tick();
            show_sel(s);
            $display("[TB] drain sel=%0d word=%h", s, bus.oWrData);
            if (s == 0) chk("drain_sel0", bus.oWrData, 32'hA3A2A1A0);
            if (s == 6) begin
                chk("drain_sel6", bus.oWrData, 32'h00BAB9B8);
                chk("drain_has", {31'b0, bus.oAllResultFifoHasData}, 32'd0);
            end
        end
        show_sel(7);
        chk("drain_sel7", bus.oWrData, 32'h0);

        // Overflow on lane 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_lane(3, 8'h30 + 8'(i));
            tick();
        end
        chk("ovf_err", {30'b0, bus.oErr}, STATUS ? 32'd1 : 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.iResultRdEn[3] = 1'b1;
            tick();
            show_sel(0);
            chk("ovf_order", {24'b0, bus.oWrData[31:24]}, {24'b0, 8'h30 + 8'(i)});
            $display("[TB] overflow pop %0d value=%h", i, bus.oWrData[31:24]);
        end

        // Underflow and clear on lane 7
        push_lane(7, 8'h77);
        tick();
        bus.iResultRdEn[7] = 1'b1;
        tick();
        show_sel(1);
        chk("udf_prev", {24'b0, bus.oWrData[31:24]}, 32'h77);
        bus.iResultRdEn[7] = 1'b1;
        tick();
        chk("udf_zero", {24'b0, bus.oWrData[31:24]}, 32'h0);
        chk("udf_err", {30'b0, bus.oErr}, STATUS ? 32'd3 : 32'd0);
        bus.iClrErr = 1'b1;
        tick();
        chk("clr_err", {30'b0, bus.oErr}, 32'd0);
        $display("[TB] underflow/clear err=%b", bus.oErr);

        // Simultaneous push and pop on a full lane 5
        for (int i = 0; i < 4; i++) begin
            push_lane(5, 8'h50 + 8'(i));
            tick();
        end
        push_lane(5, 8'h54);
        bus.iResultRdEn[5] = 1'b1;
        tick();
        show_sel(1);
        chk("pp_oldest", {24'b0, bus.oWrData[15:8]}, 32'h50);
        chk("pp_no_ovf", {30'b0, bus.oErr}, 32'd0);
        chk("pp_model_cnt", 32'(q_m[5].size()), 32'd4);
        for (int i = 1; i < 5; i++) begin
            bus.iResultRdEn[5] = 1'b1;
            tick();
            chk("pp_order", {24'b0, bus.oWrData[15:8]}, {24'b0, 8'h50 + 8'(i)});
            $display("[TB] push+pop drain %0d value=%h", i, bus.oWrData[15:8]);
        end

        // Reset mid-operation with lanes partly filled
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 10; k++) push_lane(k, 8'hC0 + 8'(k) + 8'(16*r));
            tick();
        end
        push_all(8'h11);
        tick();
        bus.iResultRdEn = '1;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_has", {31'b0, bus.oAllResultFifoHasData}, 32'd0);
        for (int s = 0; s < 8; s++) begin
            show_sel(s);
            chk("mid_rst_word", bus.oWrData, 32'h0);
        end
        rst = 1'b0;
        tick();
        bus.iResultRdEn = '1;
        tick();
        for (int s = 0; s < 8; s++) begin
            show_sel(s);
            chk("no_stale", bus.oWrData, 32'h0);
        end
        $display("[TB] mid-operation reset done");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.iResultValid = LANES'($urandom) & LANES'($urandom);
            for (int k = 0; k < LANES; k++) bus.iResultData[8*k +: 8] = 8'($urandom);
            bus.iResultRdEn = LANES'($urandom) & LANES'($urandom);
            bus.iClrErr = ($urandom_range(0, 15) == 0);
            tick();
            bus.iResultFifoSel = 3'($urandom);
            if (n % 100 == 0) $display("[TB] random cycle %0d word=%h has=%b", n, bus.oWrData, bus.oAllResultFifoHasData);
        end
        rst = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
